// File: rtl/md_issue_ctrl.sv
// Issue/sequencing controller for the iterative mult/div engine: latches one op,
// runs the engine handshake, writes HI/LO and raises the EX stall while busy.
module md_issue_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        mfhi_req,
    input  logic        mflo_req,
    input  logic        mthi_wr,
    input  logic        mtlo_wr,
    output logic        eng_start,
    output logic        eng_is_div,
    output logic        eng_signed,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    output logic        eng_annul,
    input  logic        eng_ready,
    input  logic [63:0] eng_result,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        stall,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, START, BUSY, WB} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              is_div_reg, signed_reg;
    logic [31:0]       a_reg, b_reg;
    logic [63:0]       res_reg;
    logic              hi_kill_reg, lo_kill_reg;

    logic accept, div_zero, cnt_hit;

    assign accept   = (state_reg == IDLE) && op_valid && !flush;
    assign div_zero = op_code[1] && (src_b == 32'h0);
    assign cnt_hit  = (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            is_div_reg  <= 1'b0;
            signed_reg  <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            res_reg     <= '0;
            hi_kill_reg <= 1'b0;
            lo_kill_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                is_div_reg <= op_code[1];
                signed_reg <= ~op_code[0];
                a_reg      <= src_a;
                b_reg      <= src_b;
                // Divide by zero bypasses the engine with a fixed result.
                if (div_zero)
                    res_reg <= {src_a, 32'h0};
            end
            if (state_reg == START)
                cnt_reg <= '0;
            else if (state_reg == BUSY)
                cnt_reg <= cnt_reg + CNT_W'(1);
            if (state_reg == BUSY && eng_ready && !flush)
                res_reg <= eng_result;
            if (state_reg == IDLE || state_next == IDLE) begin
                hi_kill_reg <= 1'b0;
                lo_kill_reg <= 1'b0;
            end else begin
                hi_kill_reg <= hi_kill_reg | mthi_wr;
                lo_kill_reg <= lo_kill_reg | mtlo_wr;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (accept) state_next = div_zero ? WB : START;
            START: state_next = flush ? IDLE : BUSY;
            BUSY: begin
                if (flush)          state_next = IDLE;
                else if (eng_ready) state_next = WB;
                else if (cnt_hit)   state_next = IDLE;
            end
            WB:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        eng_start   = 1'b0;
        eng_annul   = 1'b0;
        timeout_err = 1'b0;
        hi_we       = 1'b0;
        lo_we       = 1'b0;
        case (state_reg)
            START: begin
                eng_start = !flush;
                eng_annul = flush;
            end
            BUSY: begin
                // A ready arriving on the last watchdog cycle still wins.
                eng_annul   = flush || (!eng_ready && cnt_hit);
                timeout_err = !flush && !eng_ready && cnt_hit;
            end
            WB: begin
                hi_we = !hi_kill_reg && !mthi_wr;
                lo_we = !lo_kill_reg && !mtlo_wr;
            end
            default: ;
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign stall      = busy && (mfhi_req || mflo_req || op_valid) && !flush;
    assign eng_is_div = is_div_reg;
    assign eng_signed = signed_reg;
    assign eng_a      = a_reg;
    assign eng_b      = b_reg;
    assign hi_wdata   = res_reg[63:32];
    assign lo_wdata   = res_reg[31:0];

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios plus randomized ops checked against
// a per-operation timeline model built from arithmetic results.
module tb_md_issue_ctrl;

    logic        clk, rst;
    logic        op_valid, flush, mfhi_req, mflo_req, mthi_wr, mtlo_wr, eng_ready;
    logic [1:0]  op_code;
    logic [31:0] src_a, src_b;
    logic [63:0] eng_result;
    logic        eng_start, eng_is_div, eng_signed, eng_annul;
    logic        hi_we, lo_we, stall, busy, timeout_err;
    logic [31:0] eng_a, eng_b, hi_wdata, lo_wdata;
    logic [6:0]  ctl;

    int ncmp = 0;
    int nerr = 0;

    md_issue_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .src_a(src_a), .src_b(src_b), .flush(flush), .mfhi_req(mfhi_req),
        .mflo_req(mflo_req), .mthi_wr(mthi_wr), .mtlo_wr(mtlo_wr),
        .eng_start(eng_start), .eng_is_div(eng_is_div), .eng_signed(eng_signed),
        .eng_a(eng_a), .eng_b(eng_b), .eng_annul(eng_annul), .eng_ready(eng_ready),
        .eng_result(eng_result), .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata),
        .lo_wdata(lo_wdata), .stall(stall), .busy(busy), .timeout_err(timeout_err)
    );

    // {eng_start, eng_annul, hi_we, lo_we, stall, busy, timeout_err}
    assign ctl = {eng_start, eng_annul, hi_we, lo_we, stall, busy, timeout_err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        op_valid = 0; op_code = 0; src_a = 0; src_b = 0; flush = 0;
        mfhi_req = 0; mflo_req = 0; mthi_wr = 0; mtlo_wr = 0;
        eng_ready = 0; eng_result = 0;
    endtask

    task automatic issue(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1; op_code = opc; src_a = a; src_b = b;
        #2;
        ncmp++; if (ctl !== 7'b0) begin nerr++; $display("FAIL issue_idle_ctl got=%b exp=%b", ctl, 7'b0); end
        tick();
        op_valid = 0; src_a = $urandom; src_b = $urandom;
    endtask

    function automatic logic [63:0] ref_result(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int qa, qb;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        qa = int'(a); qb = int'(b);
        case (opc)
            2'd0: return 64'(sa * sb);
            2'd1: return {32'h0, a} * {32'h0, b};
            2'd2: return (b == 0) ? {a, 32'h0} : {32'(qa % qb), 32'(qa / qb)};
            default: return (b == 0) ? {a, 32'h0} : {a % b, a / b};
        endcase
    endfunction

    task automatic test_reset();
        rst = 0; op_valid = 1; mfhi_req = 1; src_a = 32'h1234; src_b = 32'h5;
        repeat (2) tick();
        #2;
        ncmp++; if (ctl !== 7'b0) begin nerr++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0); end
        ncmp++; if ({eng_a, eng_b} !== 64'h0) begin nerr++; $display("FAIL reset_operands got=%h exp=0", {eng_a, eng_b}); end
        ncmp++; if ({hi_wdata, lo_wdata, eng_is_div, eng_signed} !== 66'h0) begin nerr++; $display("FAIL reset_data got=%h exp=0", {hi_wdata, lo_wdata, eng_is_div, eng_signed}); end
        idle_inputs();
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_mult();
        logic [6:0] ex;
        issue(2'd0, 32'hFFFFFFFD, 32'd7);
        for (int k = 0; k <= 5; k++) begin
            eng_ready = (k == 4);
            eng_result = (k == 4) ? {32'hFFFFFFFF, 32'hFFFFFFEB} : 64'h0;
            ex = (k == 0) ? 7'b1000010 : (k == 5) ? 7'b0011010 : 7'b0000010;
            #2;
            ncmp++; if (ctl !== ex) begin nerr++; $display("FAIL mult_ctl k=%0d got=%b exp=%b", k, ctl, ex); end
            if (k == 0) begin
                ncmp++; if ({eng_a, eng_b, eng_is_div, eng_signed} !== {32'hFFFFFFFD, 32'd7, 2'b01}) begin nerr++; $display("FAIL mult_operands got=%h/%h/%b%b", eng_a, eng_b, eng_is_div, eng_signed); end
            end
            if (k == 5) begin
                ncmp++; if ({hi_wdata, lo_wdata} !== 64'hFFFFFFFF_FFFFFFEB) begin nerr++; $display("FAIL mult_wdata got=%h exp=ffffffffffffffeb", {hi_wdata, lo_wdata}); end
            end
            tick();
        end
        eng_ready = 0;
        #2;
        ncmp++; if (ctl !== 7'b0) begin nerr++; $display("FAIL mult_after got=%b exp=0", ctl); end
    endtask

    task automatic test_divu_stall();
        logic [6:0] ex;
        issue(2'd3, 32'd100, 32'd7);
        mflo_req = 1;
        for (int k = 0; k <= 4; k++) begin
            eng_ready = (k == 3);
            eng_result = {32'd2, 32'd14};
            ex = (k == 0) ? 7'b1000110 : (k == 4) ? 7'b0011110 : 7'b0000110;
            #2;
            ncmp++; if (ctl !== ex) begin nerr++; $display("FAIL divu_ctl k=%0d got=%b exp=%b", k, ctl, ex); end
            if (k == 4) begin
                ncmp++; if ({hi_wdata, lo_wdata} !== {32'd2, 32'd14}) begin nerr++; $display("FAIL divu_wdata got=%h exp=%h", {hi_wdata, lo_wdata}, {32'd2, 32'd14}); end
            end
            tick();
        end
        eng_ready = 0;
        #2;
        ncmp++; if (ctl !== 7'b0) begin nerr++; $display("FAIL divu_stall_release got=%b exp=0", ctl); end
        mflo_req = 0;
    endtask

    task automatic test_div_zero();
        issue(2'd2, 32'd5, 32'd0);
        #2;
        ncmp++; if (ctl !== 7'b0011010) begin nerr++; $display("FAIL divzero_ctl got=%b exp=%b", ctl, 7'b0011010); end
        ncmp++; if ({hi_wdata, lo_wdata} !== {32'd5, 32'd0}) begin nerr++; $display("FAIL divzero_wdata got=%h exp=%h", {hi_wdata, lo_wdata}, {32'd5, 32'd0}); end
        tick();
        #2;
        ncmp++; if (ctl !== 7'b0) begin nerr++; $display("FAIL divzero_after got=%b exp=0", ctl); end
    endtask

    task automatic test_mt_kill();
        logic [6:0] ex;
        // MTHI during BUSY, then MTLO during WB itself.
        for (int pass = 0; pass < 2; pass++) begin
            issue(2'd1, 32'd40000, 32'd3);
            for (int k = 0; k <= 4; k++) begin
                eng_ready = (k == 3);
                eng_result = 64'd120000;
                mthi_wr = (pass == 0) && (k == 2);
                mtlo_wr = (pass == 1) && (k == 4);
                ex = (k == 0) ? 7'b1000010 : (k != 4) ? 7'b0000010 : (pass == 0) ? 7'b0001010 : 7'b0010010;
                #2;
                ncmp++; if (ctl !== ex) begin nerr++; $display("FAIL mtkill_ctl pass=%0d k=%0d got=%b exp=%b", pass, k, ctl, ex); end
                tick();
            end
            idle_inputs();
        end
    endtask

    task automatic test_flush();
        // Flush alongside op_valid in IDLE: not accepted.
        op_valid = 1; flush = 1; op_code = 2'd0; src_a = 3; src_b = 4;
        tick();
        op_valid = 0; flush = 0;
        #2;
        ncmp++; if (ctl !== 7'b0) begin nerr++; $display("FAIL flush_idle_reject got=%b exp=0", ctl); end
        issue(2'd0, 32'd9, 32'd9);
        for (int k = 0; k <= 2; k++) begin
            flush = (k == 2);
            #2;
            ncmp++; if (ctl !== ((k == 0) ? 7'b1000010 : (k == 2) ? 7'b0100010 : 7'b0000010)) begin nerr++; $display("FAIL flush_ctl k=%0d got=%b", k, ctl); end
            tick();
        end
        flush = 0; eng_ready = 1; eng_result = 64'd81;
        #2;
        ncmp++; if (ctl !== 7'b0) begin nerr++; $display("FAIL flush_after got=%b exp=0", ctl); end
        tick();
        eng_ready = 0;
        issue(2'd0, 32'd2, 32'd3);
        for (int k = 0; k <= 2; k++) begin
            eng_ready = (k == 1); eng_result = 64'd6;
            #2;
            ncmp++; if (ctl !== ((k == 0) ? 7'b1000010 : (k == 2) ? 7'b0011010 : 7'b0000010)) begin nerr++; $display("FAIL flush_next_ctl k=%0d got=%b", k, ctl); end
            if (k == 2) begin
                ncmp++; if ({hi_wdata, lo_wdata} !== 64'd6) begin nerr++; $display("FAIL flush_next_wdata got=%h exp=6", {hi_wdata, lo_wdata}); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        logic [6:0] ex;
        issue(2'd1, 32'd1, 32'd1);
        for (int k = 0; k <= 8; k++) begin
            ex = (k == 0) ? 7'b1000010 : (k == 8) ? 7'b0100011 : 7'b0000010;
            #2;
            ncmp++; if (ctl !== ex) begin nerr++; $display("FAIL timeout_ctl k=%0d got=%b exp=%b", k, ctl, ex); end
            tick();
        end
        eng_ready = 1; eng_result = 64'd1;
        #2;
        ncmp++; if (ctl !== 7'b0) begin nerr++; $display("FAIL timeout_idle got=%b exp=0", ctl); end
        tick();
        eng_ready = 0;
    endtask

    task automatic test_async_reset();
        issue(2'd0, 32'd11, 32'd13);
        tick();
        tick();
        mflo_req = 1;
        #2;
        rst = 0;
        #1;
        ncmp++; if (ctl !== 7'b0) begin nerr++; $display("FAIL async_reset_ctl got=%b exp=0", ctl); end
        ncmp++; if ({eng_a, eng_b} !== 64'h0) begin nerr++; $display("FAIL async_reset_operands got=%h exp=0", {eng_a, eng_b}); end
        idle_inputs();
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_random();
        logic [1:0]  opc;
        logic [31:0] a, b;
        logic [63:0] exp_res;
        logic [6:0]  ex;
        logic        dz, aborted, fl, rdy_ok, in_wb;
        int lat, flush_at, mthi_at, mtlo_at, last;
        for (int n = 0; n < 60; n++) begin
            opc = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            if (a == 32'h80000000) a = 32'h1;
            if (opc[1] && ($urandom_range(0, 3) == 0)) b = 0;
            if (($urandom_range(0, 2) == 0)) b = 32'($urandom_range(0, 20));
            dz = opc[1] && (b == 0);
            lat = $urandom_range(1, 8);
            exp_res = ref_result(opc, a, b);
            flush_at = (!dz && $urandom_range(0, 2) == 0) ? $urandom_range(0, lat) : 99;
            mthi_at = ($urandom_range(0, 2) == 0) ? (dz ? 0 : $urandom_range(0, lat + 1)) : 99;
            mtlo_at = ($urandom_range(0, 2) == 0) ? (dz ? 0 : $urandom_range(0, lat + 1)) : 99;
            aborted = (flush_at <= lat);
            last = dz ? 0 : (aborted ? flush_at : lat + 1);
            mfhi_req = 1'($urandom); mflo_req = 1'($urandom);
            issue(opc, a, b);
            for (int k = 0; k <= last; k++) begin
                fl = (k == flush_at);
                flush = fl; mthi_wr = (k == mthi_at); mtlo_wr = (k == mtlo_at);
                mfhi_req = 1'($urandom); mflo_req = 1'($urandom); op_valid = 1'($urandom);
                rdy_ok = !dz && (k == lat);
                eng_ready = rdy_ok || ((k == 0) && 1'($urandom));
                eng_result = rdy_ok ? exp_res : {$urandom, $urandom};
                in_wb = !aborted && (k == last);
                ex = {!dz && (k == 0) && !fl, aborted && (k == last),
                      in_wb && (mthi_at > k), in_wb && (mtlo_at > k),
                      (mfhi_req || mflo_req || op_valid) && !fl, 1'b1, 1'b0};
                #2;
                ncmp++; if (ctl !== ex) begin nerr++; $display("FAIL rand_ctl op=%0d opc=%0d k=%0d got=%b exp=%b", n, opc, k, ctl, ex); end
                if (in_wb) begin
                    ncmp++; if ({hi_wdata, lo_wdata} !== exp_res) begin nerr++; $display("FAIL rand_wdata op=%0d got=%h exp=%h", n, {hi_wdata, lo_wdata}, exp_res); end
                end
                if (k == 0 && !dz) begin
                    ncmp++; if ({eng_a, eng_b, eng_is_div, eng_signed} !== {a, b, opc[1], ~opc[0]}) begin nerr++; $display("FAIL rand_operands op=%0d got=%h/%h/%b%b", n, eng_a, eng_b, eng_is_div, eng_signed); end
                end
                tick();
            end
            idle_inputs();
        end
        #2;
        ncmp++; if (ctl !== 7'b0) begin nerr++; $display("FAIL rand_final_idle got=%b exp=0", ctl); end
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        test_reset();
        test_mult();
        test_divu_stall();
        test_div_zero();
        test_mt_kill();
        test_flush();
        test_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
